sram_1rw_arbiter: RTL and testbench

//  Shares one 1RW SRAM macro (e.g. sram_32x16384_1rw) between two requesters.
//  - Per-port valid/ready request channel; round-robin arbitration.
//  - Drives the macro pins; returns each read on a registered per-port response slot.
//  - Sits between cache/ctrl logic and the hard macro in the nangate45 flow.

---
 rtl/sram_arb_pkg.sv | 17 +
 rtl/sram_1rw_arbiter_if.sv | 31 +++
 rtl/sram_arb_rr2.sv | 28 ++
 rtl/sram_1rw_arbiter.sv | 104 ++++++++++
 tb/tb_sram_1rw_arbiter.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/sram_arb_pkg.sv
// rtl/sram_arb_pkg.sv - shared types and constants for the 1RW SRAM arbiter
package sram_arb_pkg;
    localparam int NUM_PORTS  = 2;
    localparam int BITS       = 32;
    localparam int ADDR_WIDTH = 14;

    typedef struct packed {
        logic                  we;
        logic [ADDR_WIDTH-1:0] addr;
        logic [BITS-1:0]       wdata;
        logic [BITS-1:0]       wmask;
    } sram_req_t;

    typedef struct packed {
        logic [BITS-1:0] rdata;
    } sram_rsp_t;
endpackage

// File: rtl/sram_1rw_arbiter_if.sv
// rtl/sram_1rw_arbiter_if.sv - request/response channels and macro pins of the arbiter
interface sram_1rw_arbiter_if #(
    parameter int BITS       = 32,
    parameter int ADDR_WIDTH = 14
);
    logic [1:0]              req_valid;
    logic [1:0]              req_ready;
    logic [1:0]              req_we;
    logic [2*ADDR_WIDTH-1:0] req_addr;
    logic [2*BITS-1:0]       req_wdata;
    logic [2*BITS-1:0]       req_wmask;
    logic [1:0]              rsp_valid;
    logic [1:0]              rsp_ready;
    logic [2*BITS-1:0]       rsp_rdata;
    logic                    sram_ce;
    logic                    sram_we;
    logic [ADDR_WIDTH-1:0]   sram_addr;
    logic [BITS-1:0]         sram_wd;
    logic [BITS-1:0]         sram_wmask;
    logic [BITS-1:0]         sram_rd;

    // master: requesters plus the macro; slave: the arbiter itself
    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_wmask, rsp_ready, sram_rd,
        input  req_ready, rsp_valid, rsp_rdata, sram_ce, sram_we, sram_addr, sram_wd, sram_wmask
    );
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_wmask, rsp_ready, sram_rd,
        output req_ready, rsp_valid, rsp_rdata, sram_ce, sram_we, sram_addr, sram_wd, sram_wmask
    );
endinterface

// File: rtl/sram_arb_rr2.sv
// rtl/sram_arb_rr2.sv - two-way round-robin picker, one grant per cycle
module sram_arb_rr2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] i_elig,
    output logic [1:0] o_grant
);
    logic r_rr_ptr;
    logic w_both;

    assign w_both = &i_elig;

    always_comb begin
        o_grant = i_elig;
        if (w_both) begin
            o_grant = r_rr_ptr ? 2'b10 : 2'b01;
        end
    end

    // pointer only moves on contention; winner is r_rr_ptr, so next favours the other
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= 1'b0;
        end else if (w_both) begin
            r_rr_ptr <= ~r_rr_ptr;
        end
    end
endmodule

// File: rtl/sram_1rw_arbiter.sv
// rtl/sram_1rw_arbiter.sv - shares one 1RW SRAM macro between two ports; SRAM_ARB_STATS_EN adds counters
module sram_1rw_arbiter
    import sram_arb_pkg::*;
#(
    parameter int BITS       = sram_arb_pkg::BITS,
    parameter int ADDR_WIDTH = sram_arb_pkg::ADDR_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sram_1rw_arbiter_if.slave    bus
`ifdef SRAM_ARB_STATS_EN
    ,
    output logic [31:0]          stat_grant0,
    output logic [31:0]          stat_grant1,
    output logic [31:0]          stat_conflict
`endif
);
    logic [1:0] w_elig;
    logic [1:0] w_grant;
    logic [1:0] r_inflight;
    logic [1:0] r_rsp_valid;
    sram_rsp_t  r_slot [NUM_PORTS];
    sram_req_t  w_req  [NUM_PORTS];
    sram_req_t  w_win_req;

    // rst_n gating keeps the macro idle while reset is held, not just after the next edge
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            w_req[i].we    = bus.req_we[i];
            w_req[i].addr  = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            w_req[i].wdata = bus.req_wdata[i*BITS +: BITS];
            w_req[i].wmask = bus.req_wmask[i*BITS +: BITS];
            w_elig[i] = rst_n & bus.req_valid[i] &
                        (bus.req_we[i] | (~r_inflight[i] & (~r_rsp_valid[i] | bus.rsp_ready[i])));
        end
    end

    sram_arb_rr2 u_rr (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_elig  (w_elig),
        .o_grant (w_grant)
    );

    always_comb begin
        w_win_req = '0;
        if (w_grant[0]) begin
            w_win_req = w_req[0];
        end else if (w_grant[1]) begin
            w_win_req = w_req[1];
        end
    end

    assign bus.req_ready  = w_grant;
    assign bus.sram_ce    = |w_grant;
    assign bus.sram_we    = w_win_req.we;
    assign bus.sram_addr  = w_win_req.addr;
    assign bus.sram_wd    = w_win_req.wdata;
    assign bus.sram_wmask = w_win_req.wmask;
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_rdata  = {r_slot[1].rdata, r_slot[0].rdata};

    // macro data appears the cycle after the read grant; a capture beats a same-cycle drain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inflight  <= '0;
            r_rsp_valid <= '0;
            r_slot[0]   <= '0;
            r_slot[1]   <= '0;
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                r_inflight[i] <= w_grant[i] & ~bus.req_we[i];
                if (r_inflight[i]) begin
                    r_rsp_valid[i]  <= 1'b1;
                    r_slot[i].rdata <= bus.sram_rd;
                end else if (r_rsp_valid[i] && bus.rsp_ready[i]) begin
                    r_rsp_valid[i] <= 1'b0;
                end
            end
        end
    end

`ifdef SRAM_ARB_STATS_EN
    logic [31:0] r_stat_grant0;
    logic [31:0] r_stat_grant1;
    logic [31:0] r_stat_conflict;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_grant0   <= '0;
            r_stat_grant1   <= '0;
            r_stat_conflict <= '0;
        end else begin
            if (w_grant[0] && (r_stat_grant0 != '1)) r_stat_grant0 <= r_stat_grant0 + 32'd1;
            if (w_grant[1] && (r_stat_grant1 != '1)) r_stat_grant1 <= r_stat_grant1 + 32'd1;
            if ((&bus.req_valid) && (r_stat_conflict != '1)) r_stat_conflict <= r_stat_conflict + 32'd1;
        end
    end

    assign stat_grant0   = r_stat_grant0;
    assign stat_grant1   = r_stat_grant1;
    assign stat_conflict = r_stat_conflict;
`endif
endmodule

// File: tb/tb_sram_1rw_arbiter.sv
// tb/tb_sram_1rw_arbiter.sv - directed vector bench for sram_1rw_arbiter with a behavioural macro
module tb_sram_1rw_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sram_1rw_arbiter_if #(.BITS(32), .ADDR_WIDTH(14)) bus ();

`ifdef SRAM_ARB_STATS_EN
    logic [31:0] stat_grant0, stat_grant1, stat_conflict;
`endif

    sram_1rw_arbiter #(.BITS(32), .ADDR_WIDTH(14)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus)
`ifdef SRAM_ARB_STATS_EN
        ,
        .stat_grant0   (stat_grant0),
        .stat_grant1   (stat_grant1),
        .stat_conflict (stat_conflict)
`endif
    );

    // macro model: registered read, bit-masked write
    logic [31:0] mem [0:16383];
    logic [31:0] r_rd;
    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = 32'h0;
        r_rd = 32'h0;
    end
    always @(posedge clk) begin
        if (bus.sram_ce) begin
            if (bus.sram_we)
                mem[bus.sram_addr] <= (mem[bus.sram_addr] & ~bus.sram_wmask) | (bus.sram_wd & bus.sram_wmask);
            else
                r_rd <= mem[bus.sram_addr];
        end
    end
    assign bus.sram_rd = r_rd;

    typedef struct {
        logic [1:0]  v, we, rr;
        logic [13:0] a0, a1;
        logic [31:0] wd0, wm0;
        logic [1:0]  e_rdy;
        logic        e_ce, e_we;
        logic [13:0] e_addr;
        logic [1:0]  e_rv;
        logic [31:0] e_rd0, e_rd1;
    } vec_t;

    int n_vec  = 0;
    int n_miss = 0;

    function automatic vec_t mk(logic [1:0] v, logic [1:0] we, logic [1:0] rr,
                                logic [13:0] a0, logic [13:0] a1, logic [31:0] wd0, logic [31:0] wm0,
                                logic [1:0] e_rdy, logic e_ce, logic e_we, logic [13:0] e_addr,
                                logic [1:0] e_rv, logic [31:0] e_rd0, logic [31:0] e_rd1);
        vec_t t;
        t.v = v; t.we = we; t.rr = rr; t.a0 = a0; t.a1 = a1; t.wd0 = wd0; t.wm0 = wm0;
        t.e_rdy = e_rdy; t.e_ce = e_ce; t.e_we = e_we; t.e_addr = e_addr;
        t.e_rv = e_rv; t.e_rd0 = e_rd0; t.e_rd1 = e_rd1;
        return t;
    endfunction

    task automatic drive(input vec_t t, input logic [31:0] wd1);
        bus.req_valid = t.v;
        bus.req_we    = t.we;
        bus.rsp_ready = t.rr;
        bus.req_addr  = {t.a1, t.a0};
        bus.req_wdata = {wd1, t.wd0};
        bus.req_wmask = {32'hFFFF_FFFF, t.wm0};
    endtask

    task automatic check(input string nm, input vec_t t);
        n_vec++;
        if (bus.req_ready !== t.e_rdy || bus.sram_ce !== t.e_ce || bus.sram_we !== t.e_we ||
            bus.sram_addr !== t.e_addr || bus.rsp_valid !== t.e_rv ||
            bus.rsp_rdata[31:0] !== t.e_rd0 || bus.rsp_rdata[63:32] !== t.e_rd1) begin
            n_miss++;
            $display("FAIL %s: got rdy=%b ce=%b we=%b addr=%h rv=%b rd0=%h rd1=%h ; want rdy=%b ce=%b we=%b addr=%h rv=%b rd0=%h rd1=%h",
                     nm, bus.req_ready, bus.sram_ce, bus.sram_we, bus.sram_addr, bus.rsp_valid,
                     bus.rsp_rdata[31:0], bus.rsp_rdata[63:32],
                     t.e_rdy, t.e_ce, t.e_we, t.e_addr, t.e_rv, t.e_rd0, t.e_rd1);
        end
    endtask

    localparam logic [31:0] DB = 32'hDEAD_BEEF;
    localparam logic [31:0] D5 = 32'hDEAD_5678;
    localparam logic [31:0] A5 = 32'hAAAA_5555;
    localparam logic [31:0] F  = 32'hFFFF_FFFF;

    vec_t tbl [22];
    vec_t idle;

    initial begin
        idle = mk(2'b00, 2'b00, 2'b00, 14'h0, 14'h0, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0, 14'h0, 2'b00, 32'h0, 32'h0);
        // full write, then read-back with 2-cycle latency and drain
        tbl[0]  = mk(2'b01, 2'b01, 2'b00, 14'h10, 14'h0, DB, F, 2'b01, 1'b1, 1'b1, 14'h10, 2'b00, 32'h0, 32'h0);
        tbl[1]  = mk(2'b01, 2'b00, 2'b00, 14'h10, 14'h0, 32'h0, 32'h0, 2'b01, 1'b1, 1'b0, 14'h10, 2'b00, 32'h0, 32'h0);
        tbl[2]  = mk(2'b00, 2'b00, 2'b00, 14'h0, 14'h0, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0, 14'h0, 2'b00, 32'h0, 32'h0);
        tbl[3]  = mk(2'b00, 2'b00, 2'b00, 14'h0, 14'h0, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0, 14'h0, 2'b01, DB, 32'h0);
        tbl[4]  = mk(2'b00, 2'b00, 2'b01, 14'h0, 14'h0, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0, 14'h0, 2'b01, DB, 32'h0);
        tbl[5]  = mk(2'b00, 2'b00, 2'b00, 14'h0, 14'h0, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0, 14'h0, 2'b00, DB, 32'h0);
        // partial write over DEADBEEF, read back
        tbl[6]  = mk(2'b01, 2'b01, 2'b00, 14'h10, 14'h0, 32'h1234_5678, 32'h0000_FFFF, 2'b01, 1'b1, 1'b1, 14'h10, 2'b00, DB, 32'h0);
        tbl[7]  = mk(2'b01, 2'b00, 2'b00, 14'h10, 14'h0, 32'h0, 32'h0, 2'b01, 1'b1, 1'b0, 14'h10, 2'b00, DB, 32'h0);
        tbl[8]  = mk(2'b00, 2'b00, 2'b00, 14'h0, 14'h0, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0, 14'h0, 2'b00, DB, 32'h0);
        tbl[9]  = mk(2'b00, 2'b00, 2'b01, 14'h0, 14'h0, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0, 14'h0, 2'b01, D5, 32'h0);
        // port1 read, then held slot blocks further port1 reads while port0 writes proceed
        tbl[10] = mk(2'b10, 2'b00, 2'b00, 14'h0, 14'h10, 32'h0, 32'h0, 2'b10, 1'b1, 1'b0, 14'h10, 2'b00, D5, 32'h0);
        tbl[11] = mk(2'b10, 2'b00, 2'b00, 14'h0, 14'h20, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0, 14'h0, 2'b00, D5, 32'h0);
        for (int k = 12; k <= 16; k++)
            tbl[k] = mk(2'b11, 2'b01, 2'b00, 14'h20, 14'h20, A5, F, 2'b01, 1'b1, 1'b1, 14'h20, 2'b10, D5, D5);
        tbl[17] = mk(2'b11, 2'b01, 2'b10, 14'h20, 14'h20, A5, F, 2'b01, 1'b1, 1'b1, 14'h20, 2'b10, D5, D5);
        tbl[18] = mk(2'b11, 2'b01, 2'b10, 14'h20, 14'h20, A5, F, 2'b10, 1'b1, 1'b0, 14'h20, 2'b00, D5, D5);
        tbl[19] = mk(2'b11, 2'b01, 2'b10, 14'h20, 14'h20, A5, F, 2'b01, 1'b1, 1'b1, 14'h20, 2'b00, D5, D5);
        tbl[20] = mk(2'b00, 2'b00, 2'b10, 14'h0, 14'h0, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0, 14'h0, 2'b10, D5, A5);
        tbl[21] = mk(2'b00, 2'b00, 2'b00, 14'h0, 14'h0, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0, 14'h0, 2'b00, D5, A5);

        drive(idle, 32'h0);
        @(negedge clk);
        check("reset_state", idle);
        rst_n = 1'b1;

        for (int k = 0; k < 22; k++) begin
            @(posedge clk); #1;
            drive(tbl[k], 32'h0);
            @(negedge clk);
            check($sformatf("row%0d", k), tbl[k]);
        end

        // continuous contention from reset must alternate starting with port0
        @(posedge clk); #1;
        drive(idle, 32'h0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            vec_t t;
            @(posedge clk); #1;
            t = mk(2'b11, 2'b11, 2'b00, 14'h100, 14'h200, 32'h1111_0000, F,
                   (k % 2 == 0) ? 2'b01 : 2'b10, 1'b1, 1'b1, (k % 2 == 0) ? 14'h100 : 14'h200,
                   2'b00, 32'h0, 32'h0);
            drive(t, 32'h2222_0000);
            @(negedge clk);
            check($sformatf("rr_alt%0d", k), t);
        end

        // reset the cycle after a read grant: the in-flight read must vanish
        begin
            vec_t t;
            @(posedge clk); #1;
            t = mk(2'b01, 2'b00, 2'b00, 14'h10, 14'h0, 32'h0, 32'h0, 2'b01, 1'b1, 1'b0, 14'h10, 2'b00, 32'h0, 32'h0);
            drive(t, 32'h0);
            @(negedge clk);
            check("rst_read_grant", t);
            @(posedge clk); #1;
            rst_n = 1'b0;
            #1;
            check("rst_mid_op", idle);
            @(negedge clk);
            drive(idle, 32'h0);
            rst_n = 1'b1;
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                check($sformatf("rst_no_rsp%0d", k), idle);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end
endmodule
